reg_bus_master: RTL and testbench

REG_BUS_MASTER -- requirements
Module: reg_bus_master

---
 rtl/reg_bus_master.sv | 198 +++++++++++++++++++
 tb/tb_reg_bus_master.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_master
//  Description : Byte-stream command interpreter. It collects an opcode, a
//                16-bit address and optional write data from the host, runs a
//                single register-bus write or read cycle, and streams reply
//                bytes back to the host.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_master #(
    parameter logic [7:0] ACK_BYTE = 8'hAA,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic        reg_clk,
    input  logic        reset,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] reg_addr,
    inout  wire  [31:0] reg_data,
    output logic        reg_wr
);

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR_HI   = 4'd1,
        S_ADDR_LO   = 4'd2,
        S_WDATA     = 4'd3,
        S_WRITE     = 4'd4,
        S_RD_SETUP  = 4'd5,
        S_RD_SAMPLE = 4'd6,
        S_RESP      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        is_write;   // opcode of the command being collected
    logic [15:0] addr;       // latched target address
    logic [31:0] wdata;      // latched write data, shifted in MSB first
    logic [31:0] rbuf;       // reply shift register; top byte is on rsp_data
    logic [1:0]  byte_cnt;   // shared by WDATA collection and RESP streaming
    logic [1:0]  resp_last;  // index of the final reply byte (0 = ack, 3 = read)
    logic        drive_en;   // master owns reg_data this cycle
    logic        cmd_fire;
    logic        rsp_fire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // Data bus is only ever driven during the single write-strobe cycle.
    assign reg_data = drive_en ? wdata : {32{1'bz}};

    // State register.
    always_ff @(posedge reg_clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all outputs; bus outputs idle at address 0.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        reg_addr  = 16'h0000;
        reg_wr    = 1'b0;
        drive_en  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_data == OP_READ || cmd_data == OP_WRITE) begin
                        state_nxt = S_ADDR_HI;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_ADDR_HI: begin
                cmd_ready = !reset;
                if (cmd_valid && cmd_ready) begin
                    state_nxt = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                cmd_ready = !reset;
                if (cmd_valid && cmd_ready) begin
                    state_nxt = is_write ? S_WDATA : S_RD_SETUP;
                end
            end
            S_WDATA: begin
                cmd_ready = !reset;
                if (cmd_valid && cmd_ready && byte_cnt == 2'd3) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                reg_addr  = addr;
                reg_wr    = 1'b1;
                drive_en  = 1'b1;
                state_nxt = S_RESP;
            end
            S_RD_SETUP: begin
                reg_addr  = addr;
                state_nxt = S_RD_SAMPLE;
            end
            S_RD_SAMPLE: begin
                reg_addr  = addr;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = rbuf[31:24];
                if (rsp_valid && rsp_ready && byte_cnt == resp_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_data  = ERR_BYTE;
                if (rsp_valid && rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command capture, read sampling and reply shifting.
    always_ff @(posedge reg_clk or posedge reset) begin
        if (reset) begin
            is_write  <= 1'b0;
            addr      <= 16'h0000;
            wdata     <= 32'h0000_0000;
            rbuf      <= 32'h0000_0000;
            byte_cnt  <= 2'd0;
            resp_last <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        is_write <= (cmd_data == OP_WRITE);
                    end
                end
                S_ADDR_HI: begin
                    if (cmd_fire) begin
                        addr[15:8] <= cmd_data;
                    end
                end
                S_ADDR_LO: begin
                    if (cmd_fire) begin
                        addr[7:0] <= cmd_data;
                        byte_cnt  <= 2'd0;
                    end
                end
                S_WDATA: begin
                    if (cmd_fire) begin
                        wdata    <= {wdata[23:0], cmd_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    rbuf      <= {ACK_BYTE, 24'h000000};
                    resp_last <= 2'd0;
                    byte_cnt  <= 2'd0;
                end
                S_RD_SAMPLE: begin
                    rbuf      <= reg_data;
                    resp_last <= 2'd3;
                    byte_cnt  <= 2'd0;
                end
                S_RESP: begin
                    if (rsp_fire) begin
                        rbuf     <= {rbuf[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bus_master
//  Description : Self-checking bench for reg_bus_master with a register-bus
//                slave (memory windows plus a free-running counter at 0x0003)
//                and an address-indexed reference model of register contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_master;

    localparam logic [7:0] ACK = 8'hAA;
    localparam logic [7:0] ERR = 8'hEE;

    logic        reg_clk = 1'b0;
    logic        reset;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] reg_addr;
    wire  [31:0] reg_data;
    logic        reg_wr;

    reg_bus_master #(.ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
        .reg_clk   (reg_clk),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .reg_wr    (reg_wr)
    );

    always #5 reg_clk = ~reg_clk;

    // ---------------- slave: windows 0x0001..0x000F and 0xA5C0..0xA5CF ----
    function automatic logic mem_hit(input logic [15:0] a);
        return (a[15:4] == 12'h000 || a[15:4] == 12'hA5C) && a != 16'h0000 && a != 16'h0003;
    endfunction
    function automatic int mem_idx(input logic [15:0] a);
        return int'({a[15], a[3:0]});
    endfunction
    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'h1234_5678 : (32'h1111_0000 | 32'(i));
    endfunction

    logic [31:0] slave_mem [0:31];
    logic [31:0] slave_cnt;
    logic        slave_en;
    logic [31:0] slave_val;
    logic        preload;

    always_comb begin
        slave_en  = !reg_wr && (mem_hit(reg_addr) || reg_addr == 16'h0003);
        slave_val = (reg_addr == 16'h0003) ? slave_cnt : slave_mem[mem_idx(reg_addr)];
    end
    assign reg_data = slave_en ? slave_val : {32{1'bz}};

    always @(posedge reg_clk) begin
        if (reg_wr && reg_addr == 16'h0003) slave_cnt <= 32'd0;
        else                                slave_cnt <= slave_cnt + 32'd1;
        if (preload) begin
            for (int i = 0; i < 32; i++) slave_mem[i] <= init_val(i);
        end else if (reg_wr && mem_hit(reg_addr)) begin
            slave_mem[mem_idx(reg_addr)] <= reg_data;
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } bus_t;
    bus_t bus_q[$];
    int   wr_pulses = 0;
    int   wr_consec = 0;
    int   rd_cycles = 0;
    int   cyc = 0;
    logic prev_wr = 1'b0;

    always @(negedge reg_clk) begin
        bus_t ev;
        cyc = cyc + 1;
        if (reg_wr === 1'b1) begin
            ev.a = reg_addr;
            ev.d = reg_data;
            bus_q.push_back(ev);
            wr_pulses = wr_pulses + 1;
            if (prev_wr) wr_consec = wr_consec + 1;
        end
        if (reg_wr === 1'b0 && reg_addr != 16'h0000) rd_cycles = rd_cycles + 1;
        prev_wr = (reg_wr === 1'b1);
    end

    // ---------------- reference model and checking ----------------
    logic [31:0] model_mem [0:31];
    int checks   = 0;
    int failures = 0;
    int timeouts = 0;
    int unstable = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge reg_clk);
            n++;
        end
        if (n >= 200) timeouts++;
        @(negedge reg_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output int w, input int hold);
        int n = 0;
        logic [7:0] first;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge reg_clk);
            n++;
        end
        if (n >= 200) timeouts++;
        w = n;
        first = rsp_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge reg_clk);
            if (rsp_valid !== 1'b1 || rsp_data !== first) unstable++;
        end
        rsp_ready = 1'b1;
        b = rsp_data;
        @(negedge reg_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d,
                           input int gap, input int hold, input bit check_rd,
                           output logic [31:0] rd);
        logic [7:0] q[$];
        logic [7:0] b;
        bus_t ev;
        int w;
        int wr0 = wr_pulses;
        int rd0 = rd_cycles;
        q.push_back(op);
        if (op == 8'h01 || op == 8'h02) begin
            q.push_back(a[15:8]);
            q.push_back(a[7:0]);
        end
        if (op == 8'h02) for (int i = 3; i >= 0; i--) q.push_back(d[i*8 +: 8]);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (i != q.size() - 1) repeat ($urandom_range(0, gap)) @(negedge reg_clk);
        end
        rd = 32'h0;
        if (op == 8'h02) begin
            recv_byte(b, w, hold);
            chk("wr_ack", b, ACK);
            chk("wr_latency", w, 1);
            chk("wr_pulses", wr_pulses - wr0, 1);
            chk("wr_events", bus_q.size(), 1);
            if (bus_q.size() > 0) begin
                ev = bus_q.pop_front();
                chk("wr_addr", ev.a, a);
                chk("wr_data", ev.d, d);
            end
            if (mem_hit(a)) model_mem[mem_idx(a)] = d;
        end else if (op == 8'h01) begin
            for (int k = 0; k < 4; k++) begin
                recv_byte(b, w, hold);
                rd = {rd[23:0], b};
                if (k == 0) chk("rd_latency", w, 2);
            end
            if (check_rd) chk("rd_data", rd, model_mem[mem_idx(a)]);
            chk("rd_bus_cycles", rd_cycles - rd0, 2);
            chk("rd_no_write", wr_pulses - wr0, 0);
        end else begin
            recv_byte(b, w, hold);
            chk("err_byte", b, ERR);
            chk("err_latency", w, 0);
            chk("err_no_bus", (wr_pulses - wr0) + (rd_cycles - rd0), 0);
        end
        chk("idle_after_reply", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [3:0] lo = 4'($urandom_range(1, 15));
        if (lo == 4'd3) lo = 4'd4;
        return ($urandom_range(0, 1) != 0) ? {12'hA5C, lo} : {12'h000, lo};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  op;
        logic [15:0] a;
        int          c0;
        int          wr0;
        int          n;
        int          ub;

        for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
        reset     = 1'b1;
        preload   = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge reg_clk);

        // Reset state.
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_reg_addr", reg_addr, 16'h0000);
        chk("rst_reg_wr", reg_wr, 0);
        preload = 1'b0;
        reset   = 1'b0;
        @(negedge reg_clk);
        chk("post_rst_ready", cmd_ready, 1);

        // Read preloaded register, write it, read it back.
        run_cmd(8'h01, 16'h0005, 32'h0, 0, 0, 1'b1, rd);
        chk("rd_0005_initial", rd, 32'h1234_5678);
        run_cmd(8'h02, 16'h0005, 32'hDEAD_BEEF, 0, 0, 1'b1, rd);
        run_cmd(8'h01, 16'h0005, 32'h0, 1, 0, 1'b1, rd);

        // Unknown opcode, then a normal read.
        run_cmd(8'h7F, 16'h0, 32'h0, 0, 0, 1'b1, rd);
        run_cmd(8'h01, 16'h0005, 32'h0, 0, 0, 1'b1, rd);

        // Reply backpressure for 10 cycles on every byte.
        ub = unstable;
        run_cmd(8'h01, 16'h0005, 32'h0, 0, 10, 1'b1, rd);
        chk("bp_stable", unstable - ub, 0);

        // Reset in the middle of a write command.
        wr0 = wr_pulses;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h05); send_byte(8'hDE);
        reset = 1'b1;
        #1;
        chk("midcmd_rst_ready", cmd_ready, 0);
        repeat (2) @(negedge reg_clk);
        reset = 1'b0;
        repeat (6) @(negedge reg_clk);
        chk("midcmd_no_write", wr_pulses - wr0, 0);
        chk("midcmd_no_reply", rsp_valid, 0);
        run_cmd(8'h01, 16'h0005, 32'h0, 0, 0, 1'b1, rd);
        chk("midcmd_prior_value", rd, 32'hDEAD_BEEF);

        // Reset while a reply is pending.
        send_byte(8'h01); send_byte(8'hA5); send_byte(8'hC7);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge reg_clk);
            n++;
        end
        if (n >= 20) timeouts++;
        reset = 1'b1;
        #1;
        chk("midrsp_valid_drop", {rsp_valid, rsp_data}, 9'h000);
        @(negedge reg_clk);
        reset = 1'b0;
        repeat (4) @(negedge reg_clk);
        chk("midrsp_stays_idle", {rsp_valid, cmd_ready}, 2'b01);

        // Address 0 write still issues a bus cycle.
        run_cmd(8'h02, 16'h0000, 32'hCAFE_0001, 0, 0, 1'b1, rd);

        // Counter slave: clear by write, then read a small elapsed count.
        c0 = cyc;
        run_cmd(8'h02, 16'h0003, $urandom, 0, 0, 1'b1, rd);
        run_cmd(8'h01, 16'h0003, 32'h0, 0, 0, 1'b0, rd);
        chk("counter_range", (rd >= 32'd1 && rd <= 32'(cyc - c0)), 1);

        // Randomized commands against the model.
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(0, 9);
            a = rand_addr();
            if (n < 4) begin
                run_cmd(8'h02, a, $urandom, 2, $urandom_range(0, 3), 1'b1, rd);
            end else if (n < 8) begin
                run_cmd(8'h01, a, 32'h0, 2, $urandom_range(0, 3), 1'b1, rd);
            end else begin
                do op = 8'($urandom_range(0, 255)); while (op == 8'h01 || op == 8'h02);
                run_cmd(op, a, 32'h0, 2, $urandom_range(0, 3), 1'b1, rd);
            end
        end

        // Global invariants.
        chk("wr_never_consecutive", wr_consec, 0);
        chk("no_timeouts", timeouts, 0);
        chk("rsp_stable_all", unstable, 0);
        chk("no_stray_bus_writes", bus_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
